// File: rtl/simon_sequencer_if.sv
// Game-path bundle between the sequencer and its host: sequence load, start,
// keypad entry, and the note/status outputs.
interface simon_sequencer_if #(
    parameter int NOTE_W  = 3,
    parameter int MAX_LEN = 8,
    parameter int LIVES   = 3
);
    localparam int LVL_W = $clog2(MAX_LEN + 1);
    localparam int LIV_W = $clog2(LIVES + 1);

    logic [MAX_LEN*NOTE_W-1:0] seq_data;
    logic                      seq_load;
    logic                      start;
    logic                      key_valid;
    logic [NOTE_W:0]           key_code;
    logic [NOTE_W:0]           note_out;
    logic                      key_ready;
    logic                      miss;
    logic [LVL_W-1:0]          level;
    logic [LIV_W-1:0]          lives_left;
    logic                      game_win;
    logic                      game_over;

    modport master (
        output seq_data, seq_load, start, key_valid, key_code,
        input  note_out, key_ready, miss, level, lives_left, game_win, game_over
    );

    modport slave (
        input  seq_data, seq_load, start, key_valid, key_code,
        output note_out, key_ready, miss, level, lives_left, game_win, game_over
    );
endinterface

// File: rtl/simon_sequencer.sv
// Note-sequence memory game: plays a growing prefix of a loaded sequence, then
// checks keypad entries against it with lives, optional timeout and key echo.
module simon_sequencer #(
    parameter int NOTE_W        = 3,
    parameter int MAX_LEN       = 8,
    parameter int TICK_DIV      = 500000,
    parameter int ON_TICKS      = 2,
    parameter int OFF_TICKS     = 2,
    parameter int LIVES         = 3,
    parameter int TIMEOUT_TICKS = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    simon_sequencer_if.slave  bus
);
    localparam int LVL_W = $clog2(MAX_LEN + 1);
    localparam int LIV_W = $clog2(LIVES + 1);
    localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned D_ON  = ON_TICKS * TICK_DIV;
    localparam int unsigned D_OFF = OFF_TICKS * TICK_DIV;
    localparam int unsigned D_TO  = TIMEOUT_TICKS * TICK_DIV;
    localparam int unsigned D_MX1 = (D_ON > D_OFF) ? D_ON : D_OFF;
    localparam int unsigned D_MAX = (D_MX1 > D_TO) ? D_MX1 : D_TO;
    localparam int CNT_W = $clog2(D_MAX + 1);
    localparam int unsigned D_TO_M1 = (TIMEOUT_TICKS > 0) ? D_TO - 1 : 0;

    typedef enum logic [2:0] {
        S_IDLE, S_PLAY_ON, S_PLAY_OFF, S_GAP, S_WAIT_KEY, S_ECHO, S_WIN, S_LOSE
    } state_t;

    state_t                    r_state, w_state;
    logic [CNT_W-1:0]          r_cnt, w_cnt;
    logic [IDX_W-1:0]          r_idx, w_idx;
    logic [LVL_W-1:0]          r_level, w_level;
    logic [LIV_W-1:0]          r_lives, w_lives;
    logic                      r_loaded, w_loaded;
    logic [MAX_LEN*NOTE_W-1:0] r_code, w_code;
    logic                      r_correct, w_correct;
    logic [NOTE_W:0]           r_note, w_note;
    logic                      r_key_ready, w_key_ready;
    logic                      r_miss, w_miss;
    logic                      r_win, w_win;
    logic                      r_over, w_over;
    logic                      w_last;
    logic                      w_key_ok;

    // Played value is code+1, widened first so the top code does not wrap to 0.
    function automatic logic [NOTE_W:0] note_of(input logic [MAX_LEN*NOTE_W-1:0] code,
                                                input logic [IDX_W-1:0] idx);
        note_of = {1'b0, code[idx*NOTE_W +: NOTE_W]} + {{NOTE_W{1'b0}}, 1'b1};
    endfunction

    // Next-state, next-output and datapath update for every register.
    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        w_idx       = r_idx;
        w_level     = r_level;
        w_lives     = r_lives;
        w_loaded    = r_loaded;
        w_code      = r_code;
        w_correct   = r_correct;
        w_note      = r_note;
        w_key_ready = r_key_ready;
        w_miss      = 1'b0;
        w_win       = r_win;
        w_over      = r_over;
        w_last      = ((LVL_W'(r_idx) + LVL_W'(1'b1)) == r_level);
        w_key_ok    = (bus.key_code == note_of(r_code, r_idx));

        case (r_state)
            S_IDLE, S_WIN, S_LOSE: begin
                w_cnt = '0;
                if (bus.seq_load) begin
                    w_code   = bus.seq_data;
                    w_loaded = 1'b1;
                end else begin
                    w_code   = r_code;
                end
                if (bus.start && (r_loaded || bus.seq_load)) begin
                    w_state     = S_GAP;
                    w_level     = LVL_W'(1'b1);
                    w_lives     = LIV_W'(LIVES);
                    w_idx       = '0;
                    w_note      = '0;
                    w_key_ready = 1'b0;
                    w_win       = 1'b0;
                    w_over      = 1'b0;
                end else begin
                    w_state = r_state;
                end
            end
            S_GAP: begin
                if (r_cnt == CNT_W'(D_OFF - 1)) begin
                    w_state = S_PLAY_ON;
                    w_cnt   = '0;
                    w_note  = note_of(r_code, r_idx);
                end else begin
                    w_note  = '0;
                end
            end
            S_PLAY_ON: begin
                if (r_cnt == CNT_W'(D_ON - 1)) begin
                    w_state = S_PLAY_OFF;
                    w_cnt   = '0;
                    w_note  = '0;
                end else begin
                    w_note  = r_note;
                end
            end
            S_PLAY_OFF: begin
                if (r_cnt != CNT_W'(D_OFF - 1)) begin
                    w_note = '0;
                end else if (w_last) begin
                    w_state     = S_WAIT_KEY;
                    w_cnt       = '0;
                    w_idx       = '0;
                    w_key_ready = 1'b1;
                end else begin
                    w_state = S_PLAY_ON;
                    w_cnt   = '0;
                    w_idx   = r_idx + IDX_W'(1'b1);
                    w_note  = note_of(r_code, r_idx + IDX_W'(1'b1));
                end
            end
            S_WAIT_KEY: begin
                if (bus.key_valid) begin
                    w_state     = S_ECHO;
                    w_cnt       = '0;
                    w_correct   = w_key_ok;
                    w_note      = bus.key_code;
                    w_key_ready = 1'b0;
                    if (!w_key_ok) begin
                        w_miss  = 1'b1;
                        w_lives = r_lives - LIV_W'(1'b1);
                    end else begin
                        w_miss  = 1'b0;
                    end
                end else if ((TIMEOUT_TICKS > 0) && (r_cnt == CNT_W'(D_TO_M1))) begin
                    // A timeout is a silent miss: no echo, straight to replay or game over.
                    w_cnt       = '0;
                    w_idx       = '0;
                    w_miss      = 1'b1;
                    w_lives     = r_lives - LIV_W'(1'b1);
                    w_key_ready = 1'b0;
                    if (r_lives == LIV_W'(1'b1)) begin
                        w_state = S_LOSE;
                        w_over  = 1'b1;
                    end else begin
                        w_state = S_GAP;
                    end
                end else begin
                    w_key_ready = 1'b1;
                end
            end
            S_ECHO: begin
                if (r_cnt != CNT_W'(D_ON - 1)) begin
                    w_note = r_note;
                end else begin
                    w_cnt  = '0;
                    w_note = '0;
                    if (r_correct && !w_last) begin
                        w_state     = S_WAIT_KEY;
                        w_idx       = r_idx + IDX_W'(1'b1);
                        w_key_ready = 1'b1;
                    end else if (r_correct && (r_level == LVL_W'(MAX_LEN))) begin
                        w_state = S_WIN;
                        w_win   = 1'b1;
                    end else if (r_correct) begin
                        w_state = S_GAP;
                        w_level = r_level + LVL_W'(1'b1);
                        w_idx   = '0;
                    end else if (r_lives == '0) begin
                        w_state = S_LOSE;
                        w_over  = 1'b1;
                    end else begin
                        w_state = S_GAP;
                        w_idx   = '0;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
                w_cnt   = '0;
            end
        endcase
    end

    // State, datapath and registered outputs; reset also drops the loaded sequence.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_level     <= '0;
            r_lives     <= '0;
            r_loaded    <= 1'b0;
            r_code      <= '0;
            r_correct   <= 1'b0;
            r_note      <= '0;
            r_key_ready <= 1'b0;
            r_miss      <= 1'b0;
            r_win       <= 1'b0;
            r_over      <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_idx       <= w_idx;
            r_level     <= w_level;
            r_lives     <= w_lives;
            r_loaded    <= w_loaded;
            r_code      <= w_code;
            r_correct   <= w_correct;
            r_note      <= w_note;
            r_key_ready <= w_key_ready;
            r_miss      <= w_miss;
            r_win       <= w_win;
            r_over      <= w_over;
        end
    end

    assign bus.note_out   = r_note;
    assign bus.key_ready  = r_key_ready;
    assign bus.miss       = r_miss;
    assign bus.level      = r_level;
    assign bus.lives_left = r_lives;
    assign bus.game_win   = r_win;
    assign bus.game_over  = r_over;
endmodule

// File: tb/tb_simon_sequencer.sv
// Directed bench for simon_sequencer: playback, full win, misses, guards,
// timeout and asynchronous reset, with hand-computed expectations.
module tb_simon_sequencer;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;
    logic [3:0] exp_note [4] = '{4'd3, 4'd6, 4'd1, 4'd8};

    simon_sequencer_if #(.NOTE_W(3), .MAX_LEN(4), .LIVES(2)) bus ();

    simon_sequencer #(
        .NOTE_W(3), .MAX_LEN(4), .TICK_DIV(4), .ON_TICKS(2), .OFF_TICKS(1),
        .LIVES(2), .TIMEOUT_TICKS(3)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Starting on the first GAP cycle, check the whole playback of prefix lvl.
    task automatic play_level(input int lvl, input bit inject);
        for (int c = 0; c < 4; c++) begin
            chk("gap_note", {28'd0, bus.note_out}, 32'd0);
            chk("gap_ready", {31'd0, bus.key_ready}, 32'd0);
            tick();
        end
        for (int i = 0; i < lvl; i++) begin
            for (int c = 0; c < 8; c++) begin
                if (inject && i == 0 && c == 0) begin
                    bus.key_valid = 1'b1;
                    bus.key_code  = 4'd5;
                end
                chk("on_note", {28'd0, bus.note_out}, {28'd0, exp_note[i]});
                tick();
                bus.key_valid = 1'b0;
                bus.key_code  = 4'd0;
            end
            for (int c = 0; c < 4; c++) begin
                chk("off_note", {28'd0, bus.note_out}, 32'd0);
                chk("off_ready", {31'd0, bus.key_ready}, 32'd0);
                tick();
            end
        end
        chk("wait_ready", {31'd0, bus.key_ready}, 32'd1);
        chk("wait_level", {29'd0, bus.level}, lvl);
    endtask

    // Press a key on the first WAIT_KEY cycle and check the whole echo.
    task automatic press(input logic [3:0] k, input bit wrong, input int lives_exp);
        bus.key_valid = 1'b1;
        bus.key_code  = k;
        tick();
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        chk("echo_ready", {31'd0, bus.key_ready}, 32'd0);
        chk("echo_miss", {31'd0, bus.miss}, {31'd0, wrong});
        chk("echo_lives", {30'd0, bus.lives_left}, lives_exp);
        for (int c = 0; c < 8; c++) begin
            if (c == 1) chk("miss_pulse_end", {31'd0, bus.miss}, 32'd0);
            chk("echo_note", {28'd0, bus.note_out}, {28'd0, k});
            tick();
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk(tag, {28'd0, bus.note_out}, 32'd0);
        chk(tag, {31'd0, bus.key_ready}, 32'd0);
        chk(tag, {31'd0, bus.miss}, 32'd0);
        chk(tag, {29'd0, bus.level}, 32'd0);
        chk(tag, {30'd0, bus.lives_left}, 32'd0);
        chk(tag, {31'd0, bus.game_win}, 32'd0);
        chk(tag, {31'd0, bus.game_over}, 32'd0);
    endtask

    initial begin
        bus.seq_data  = 12'h000;
        bus.seq_load  = 1'b0;
        bus.start     = 1'b0;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'd0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_n = 1'b1;
        tick();

        // Start without a loaded sequence stays in IDLE.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) begin
            chk("noload_level", {29'd0, bus.level}, 32'd0);
            chk("noload_note", {28'd0, bus.note_out}, 32'd0);
            tick();
        end

        // Load and start together, then a full winning game.
        bus.seq_data = 12'hE2A;
        bus.seq_load = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.seq_load = 1'b0;
        bus.start    = 1'b0;
        chk("start_level", {29'd0, bus.level}, 32'd1);
        chk("start_lives", {30'd0, bus.lives_left}, 32'd2);
        play_level(1, 1'b1);
        chk("inject_lives", {30'd0, bus.lives_left}, 32'd2);
        for (int lvl = 1; lvl <= 4; lvl++) begin
            if (lvl > 1) play_level(lvl, 1'b0);
            for (int i = 0; i < lvl; i++) begin
                press(exp_note[i], 1'b0, 2);
                if (i < lvl - 1) chk("next_key_ready", {31'd0, bus.key_ready}, 32'd1);
            end
        end
        chk("win_flag", {31'd0, bus.game_win}, 32'd1);
        chk("win_over", {31'd0, bus.game_over}, 32'd0);
        chk("win_level", {29'd0, bus.level}, 32'd4);
        chk("win_lives", {30'd0, bus.lives_left}, 32'd2);
        tick();
        tick();
        chk("win_hold", {31'd0, bus.game_win}, 32'd1);
        chk("win_note", {28'd0, bus.note_out}, 32'd0);

        // Restart from WIN; two misses at level 2 end the game.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        chk("restart_win", {31'd0, bus.game_win}, 32'd0);
        chk("restart_level", {29'd0, bus.level}, 32'd1);
        play_level(1, 1'b0);
        press(4'd3, 1'b0, 2);
        play_level(2, 1'b0);
        press(4'd3, 1'b0, 2);
        press(4'd2, 1'b1, 1);
        chk("replay_level", {29'd0, bus.level}, 32'd2);
        play_level(2, 1'b0);
        press(4'd4, 1'b1, 0);
        chk("over_flag", {31'd0, bus.game_over}, 32'd1);
        chk("over_level", {29'd0, bus.level}, 32'd2);
        chk("over_lives", {30'd0, bus.lives_left}, 32'd0);
        chk("over_note", {28'd0, bus.note_out}, 32'd0);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd3;
        tick();
        bus.key_valid = 1'b0;
        chk("over_key_ignored", {28'd0, bus.note_out}, 32'd0);

        // Key code 0 is a miss; then reset in the middle of an echo.
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        play_level(1, 1'b0);
        press(4'd0, 1'b1, 1);
        chk("zero_key_level", {29'd0, bus.level}, 32'd1);
        play_level(1, 1'b0);
        press(4'd3, 1'b0, 1);
        play_level(2, 1'b0);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'd3;
        tick();
        bus.key_valid = 1'b0;
        tick();
        tick();
        chk("mid_echo_note", {28'd0, bus.note_out}, 32'd3);
        reset_n = 1'b0;
        #1;
        chk_all_zero("async_reset");
        reset_n = 1'b1;
        tick();
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int c = 0; c < 6; c++) tick();
        chk("lost_seq_level", {29'd0, bus.level}, 32'd0);
        chk("lost_seq_note", {28'd0, bus.note_out}, 32'd0);

        // Timeout: 12 idle cycles in WAIT_KEY count as a miss without echo.
        bus.seq_load = 1'b1;
        bus.start    = 1'b1;
        tick();
        bus.seq_load = 1'b0;
        bus.start    = 1'b0;
        play_level(1, 1'b0);
        for (int c = 0; c < 12; c++) begin
            chk("to_wait_miss", {31'd0, bus.miss}, 32'd0);
            chk("to_wait_ready", {31'd0, bus.key_ready}, 32'd1);
            tick();
        end
        chk("to_miss", {31'd0, bus.miss}, 32'd1);
        chk("to_lives", {30'd0, bus.lives_left}, 32'd1);
        chk("to_ready", {31'd0, bus.key_ready}, 32'd0);
        chk("to_note", {28'd0, bus.note_out}, 32'd0);
        play_level(1, 1'b0);
        for (int c = 0; c < 12; c++) tick();
        chk("to2_miss", {31'd0, bus.miss}, 32'd1);
        chk("to2_lives", {30'd0, bus.lives_left}, 32'd0);
        chk("to2_over", {31'd0, bus.game_over}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
